// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the 8-digit seven-segment scan controller:
//   - state_e     : conversion FSM states
//   - SEG_CODE    : active-low segment patterns for decimal digits 0..9
//   - SEG_BLANK   : all segments off
//   - ANODE_OFF   : no digit selected
//   - dd_step     : one shift-add-3 step of the double-dabble algorithm
//   - seg_encode  : nibble to segment pattern, non-decimal nibbles blank
//   - sat_xy/sat_val : clamp inputs to their displayable range
// -----------------------------------------------------------------------------
package seg_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CONV_V = 3'd1,
        CONV_X = 3'd2,
        CONV_Y = 3'd3,
        COMMIT = 3'd4
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] ANODE_OFF = 8'hFF;

    // Segment order is bit6..0 = g..a, active low.
    localparam logic [6:0] SEG_CODE [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h18
    };

    localparam logic [6:0]  XY_MAX  = 7'd99;
    localparam logic [13:0] VAL_MAX = 14'd9999;

    // Add 3 to every BCD digit that is 5 or more, then shift in the next
    // binary bit. Repeating this once per operand bit yields the BCD value.
    function automatic logic [15:0] dd_step(input logic [15:0] bcd,
                                            input logic        bit_in);
        logic [15:0] adj;
        for (int i = 0; i < 4; i++) begin
            adj[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3
                                                     : bcd[i*4 +: 4];
        end
        return {adj[14:0], bit_in};
    endfunction

    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        if (nib > 4'd9) begin
            return SEG_BLANK;
        end
        return SEG_CODE[nib];
    endfunction

    function automatic logic [6:0] sat_xy(input logic [6:0] v);
        return (v > XY_MAX) ? XY_MAX : v;
    endfunction

    function automatic logic [13:0] sat_val(input logic [13:0] v);
        return (v > VAL_MAX) ? VAL_MAX : v;
    endfunction

endpackage

// File: rtl/bcd_dd.sv
// -----------------------------------------------------------------------------
// bcd_dd
// Sequential double-dabble binary-to-BCD converter, one operand bit per cycle.
// A start pulse loads the operand and performs the first step in the same
// cycle, so an N-bit conversion occupies exactly N cycles starting with the
// start cycle; the result is valid (done_o=1) on the following cycle and is
// held until the next start.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   start_i    load operand_i and begin a conversion (overrides one in flight)
//   width14_i  1: convert all 14 bits of operand_i, 0: convert operand_i[6:0]
//   operand_i  binary input
//   done_o     result valid
//   bcd_o      4-digit BCD result, digit 0 in bits [3:0]
// -----------------------------------------------------------------------------
module bcd_dd
    import seg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        width14_i,
    input  logic [13:0] operand_i,
    output logic        done_o,
    output logic [15:0] bcd_o
);

    logic [13:0] sh_q,  sh_d;
    logic [15:0] bcd_q, bcd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  len_q, len_d;
    logic [13:0] ld;

    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves a signal unassigned and no latch is inferred.
        sh_d  = sh_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        len_d = len_q;
        // 7-bit operands are left-justified so the MSB is always sh[13].
        ld    = width14_i ? operand_i : {operand_i[6:0], 7'd0};

        if (start_i) begin
            sh_d  = {ld[12:0], 1'b0};
            bcd_d = dd_step(16'd0, ld[13]);
            cnt_d = 4'd1;
            len_d = width14_i ? 4'd14 : 4'd7;
        end else if (cnt_q != len_q) begin
            sh_d  = {sh_q[12:0], 1'b0};
            bcd_d = dd_step(bcd_q, sh_q[13]);
            cnt_d = cnt_q + 4'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop in the
    // design samples its inputs from the same clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q  <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            len_q <= '0;
        end else begin
            sh_q  <= sh_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
            len_q <= len_d;
        end
    end

    assign done_o = (len_q != 4'd0) && (cnt_q == len_q);
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
// Captures an (x, y, value) triple, converts the three fields to BCD with one
// shared double-dabble engine, and multiplexes the 8 resulting digits onto a
// common-anode seven-segment display.
//
// Parameters:
//   CLK_DIV   clk cycles per digit-advance tick
//   LZ_BLANK  1: blank leading zeros of the 4-digit value field
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   load     single-cycle capture request, honoured only in IDLE
//   x, y     coordinates, saturated to 99, shown as 2 digits each
//   value    number, saturated to 9999, shown as 4 digits
//   busy     capture/conversion in progress
//   anode    active-low one-hot digit select (registered)
//   cathode  active-low segments g..a (registered with anode)
//
// Digit order: idx0/1 x ones/tens, idx2/3 y ones/tens, idx4..7 value
// ones..thousands.
// -----------------------------------------------------------------------------
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int CLK_DIV  = 200000,
    parameter int LZ_BLANK = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [6:0]  x,
    input  logic [6:0]  y,
    input  logic [13:0] value,
    output logic        busy,
    output logic [7:0]  anode,
    output logic [6:0]  cathode
);

    localparam int               CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);

    // -------------------------------------------------------------------------
    // Conversion FSM
    // -------------------------------------------------------------------------
    state_e      state_q,   state_d;
    logic [3:0]  cnt_q,     cnt_d;
    logic [6:0]  x_q,       x_d;
    logic [6:0]  y_q,       y_d;
    logic [13:0] val_q,     val_d;
    logic [15:0] v_bcd_q,   v_bcd_d;
    logic [7:0]  x_bcd_q,   x_bcd_d;
    logic [31:0] disp_q,    disp_d;

    logic        dd_start;
    logic        dd_width14;
    logic [13:0] dd_operand;
    logic        dd_done;
    logic [15:0] dd_bcd;

    bcd_dd u_dd (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (dd_start),
        .width14_i (dd_width14),
        .operand_i (dd_operand),
        .done_o    (dd_done),
        .bcd_o     (dd_bcd)
    );

    // Each conversion starts on the first cycle of its state and its result
    // is picked up on the first cycle of the following state, while the
    // engine is already restarting on the next field. The y result is taken
    // straight from the engine in COMMIT so all 8 digits land together.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        x_d        = x_q;
        y_d        = y_q;
        val_d      = val_q;
        v_bcd_d    = v_bcd_q;
        x_bcd_d    = x_bcd_q;
        disp_d     = disp_q;
        dd_start   = 1'b0;
        dd_width14 = 1'b0;
        dd_operand = '0;

        unique case (state_q)
            IDLE: begin
                if (load) begin
                    x_d     = sat_xy(x);
                    y_d     = sat_xy(y);
                    val_d   = sat_val(value);
                    cnt_d   = 4'd0;
                    state_d = CONV_V;
                end
            end

            CONV_V: begin
                dd_start   = (cnt_q == 4'd0);
                dd_width14 = 1'b1;
                dd_operand = val_q;
                if (cnt_q == 4'd13) begin
                    cnt_d   = 4'd0;
                    state_d = CONV_X;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            CONV_X: begin
                dd_start   = (cnt_q == 4'd0);
                dd_operand = {7'd0, x_q};
                if (cnt_q == 4'd0 && dd_done) begin
                    v_bcd_d = dd_bcd;
                end
                if (cnt_q == 4'd6) begin
                    cnt_d   = 4'd0;
                    state_d = CONV_Y;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            CONV_Y: begin
                dd_start   = (cnt_q == 4'd0);
                dd_operand = {7'd0, y_q};
                if (cnt_q == 4'd0 && dd_done) begin
                    x_bcd_d = dd_bcd[7:0];
                end
                if (cnt_q == 4'd6) begin
                    cnt_d   = 4'd0;
                    state_d = COMMIT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            COMMIT: begin
                if (dd_done) begin
                    disp_d = {v_bcd_q, dd_bcd[7:0], x_bcd_q};
                end
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            val_q   <= '0;
            v_bcd_q <= '0;
            x_bcd_q <= '0;
            // NOTE: the display register is a handful of flops, not a RAM,
            // so it is reset; the display must come up showing zeros.
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            val_q   <= val_d;
            v_bcd_q <= v_bcd_d;
            x_bcd_q <= x_bcd_d;
            disp_q  <= disp_d;
        end
    end

    assign busy = (state_q != IDLE);

    // -------------------------------------------------------------------------
    // Display scanner: free-running, independent of the FSM.
    // idx_q is the digit to be shown at the next tick, so the first tick after
    // reset selects idx 0.
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] pre_q;
    logic [2:0]       idx_q;
    logic [7:0]       anode_q;
    logic [6:0]       cathode_q;
    logic             tick;
    logic [3:0]       cur_nib;
    logic             lz;
    logic [6:0]       seg_next;

    assign tick = (pre_q == DIV_LAST);

    always_comb begin
        cur_nib = disp_q[{idx_q, 2'b00} +: 4];
        // A value digit is a leading zero when it and every digit above it
        // are zero; idx4 (ones) is never blanked so 0 still shows as "0".
        unique case (idx_q)
            3'd5:    lz = (disp_q[31:20] == 12'd0);
            3'd6:    lz = (disp_q[31:24] == 8'd0);
            3'd7:    lz = (disp_q[31:28] == 4'd0);
            default: lz = 1'b0;
        endcase
        seg_next = ((LZ_BLANK != 0) && lz) ? SEG_BLANK : seg_encode(cur_nib);
    end

    // Anode and cathode update on the same edge so a digit never shows
    // another digit's segments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q     <= '0;
            idx_q     <= '0;
            anode_q   <= ANODE_OFF;
            cathode_q <= SEG_BLANK;
        end else if (tick) begin
            pre_q     <= '0;
            idx_q     <= idx_q + 3'd1;
            anode_q   <= ~(8'b0000_0001 << idx_q);
            cathode_q <= seg_next;
        end else begin
            pre_q     <= pre_q + 1'b1;
        end
    end

    assign anode   = anode_q;
    assign cathode = cathode_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Self-checking bench for seg_scan_ctrl with a fast scan (CLK_DIV=2).
// Expected displays come from a hand-written vector table and from a decimal
// arithmetic model of the display contents.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    localparam int CLK_DIV  = 2;
    localparam int BUSY_LEN = 29;

    typedef logic [7:0][6:0] disp_t;  // [idx] -> cathode pattern

    typedef struct packed {
        logic [6:0]  x;
        logic [6:0]  y;
        logic [13:0] v;
        disp_t       c;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [6:0]  x = '0;
    logic [6:0]  y = '0;
    logic [13:0] value = '0;
    logic        busy;
    logic [7:0]  anode;
    logic [6:0]  cathode;

    int total = 0;
    int bad   = 0;

    logic [6:0] got_c [8];
    vec_t       vecs [6];

    seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .LZ_BLANK(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .x       (x),
        .y       (y),
        .value   (value),
        .busy    (busy),
        .anode   (anode),
        .cathode (cathode)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // ---------------------------- reference model ----------------------------
    function automatic logic [6:0] seg_ref(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;
            3: return 7'h30;  4: return 7'h19;  5: return 7'h12;
            6: return 7'h02;  7: return 7'h78;  8: return 7'h00;
            9: return 7'h18;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic disp_t model_disp(input int mx, input int my, input int mv);
        disp_t r;
        int    xs, ys, vs, p;
        xs = (mx > 99) ? 99 : mx;
        ys = (my > 99) ? 99 : my;
        vs = (mv > 9999) ? 9999 : mv;
        r[0] = seg_ref(xs % 10);
        r[1] = seg_ref(xs / 10);
        r[2] = seg_ref(ys % 10);
        r[3] = seg_ref(ys / 10);
        p = 1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0 && vs < p) r[4+k] = 7'h7F;
            else                 r[4+k] = seg_ref((vs / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // --------------------------------- tasks ---------------------------------
    // Issue a load and count busy cycles. Optionally raise a second load when
    // the count reaches second_at (it should be ignored).
    task automatic run_load(input logic [6:0] lx, input logic [6:0] ly,
                            input logic [13:0] lv, input int second_at,
                            input logic [6:0] x2, input logic [6:0] y2,
                            input logic [13:0] v2, output int bcycles);
        x = lx; y = ly; value = lv; load = 1'b1;
        bcycles = 0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            load = 1'b0;
            if (!busy) break;
            bcycles++;
            if (bcycles == second_at) begin
                x = x2; y = y2; value = v2; load = 1'b1;
            end
        end
        load = 1'b0;
    endtask

    // Let the scan refresh every digit, then record what each anode shows.
    task automatic collect_scan();
        for (int i = 0; i < 8; i++) got_c[i] = 'x;
        repeat (18) @(posedge clk);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                if (anode == ~(8'b0000_0001 << i)) got_c[i] = cathode;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic check_display(input string tag, input disp_t expc);
        collect_scan();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s idx%0d", tag, i), {25'd0, got_c[i]}, {25'd0, expc[i]});
        end
    endtask

    // --------------------------------- test ----------------------------------
    initial begin
        int bc;
        int ticks;
        logic [6:0]  rx, ry;
        logic [13:0] rv;
        logic [7:0]  exp_an;

        vecs[0] = '{x: 7'd12,  y: 7'd34,  v: 14'd5678,
                    c: {7'h12, 7'h02, 7'h78, 7'h00, 7'h30, 7'h19, 7'h79, 7'h24}};
        vecs[1] = '{x: 7'd120, y: 7'd7,   v: 14'd12000,
                    c: {7'h18, 7'h18, 7'h18, 7'h18, 7'h40, 7'h78, 7'h18, 7'h18}};
        vecs[2] = '{x: 7'd0,   y: 7'd0,   v: 14'd42,
                    c: {7'h7F, 7'h7F, 7'h19, 7'h24, 7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[3] = '{x: 7'd0,   y: 7'd0,   v: 14'd0,
                    c: {7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[4] = '{x: 7'd5,   y: 7'd60,  v: 14'd100,
                    c: {7'h7F, 7'h79, 7'h40, 7'h40, 7'h02, 7'h40, 7'h40, 7'h12}};
        vecs[5] = '{x: 7'd99,  y: 7'd100, v: 14'd1000,
                    c: {7'h79, 7'h40, 7'h40, 7'h40, 7'h18, 7'h18, 7'h18, 7'h18}};

        // Reset state
        repeat (3) @(posedge clk); #1;
        check("reset anode",   {24'd0, anode},   32'hFF);
        check("reset cathode", {25'd0, cathode}, 32'h7F);
        check("reset busy",    {31'd0, busy},    32'd0);

        // Scan order after reset release: one tick every CLK_DIV edges.
        rst_n = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            ticks  = n / CLK_DIV;
            exp_an = (ticks == 0) ? 8'hFF : ~(8'b0000_0001 << ((ticks - 1) % 8));
            check($sformatf("scan edge%0d anode", n), {24'd0, anode}, {24'd0, exp_an});
        end

        // Directed table
        for (int i = 0; i < 6; i++) begin
            run_load(vecs[i].x, vecs[i].y, vecs[i].v, -1, '0, '0, '0, bc);
            check($sformatf("vec%0d busy cycles", i), bc, BUSY_LEN);
            check_display($sformatf("vec%0d", i), vecs[i].c);
        end

        // Load 5 cycles into a conversion is ignored
        run_load(7'd21, 7'd43, 14'd8765, 5, 7'd98, 7'd76, 14'd1234, bc);
        check("busy load busy cycles", bc, BUSY_LEN);
        repeat (3) @(posedge clk); #1;
        check("busy load no restart", {31'd0, busy}, 32'd0);
        check_display("busy load", model_disp(21, 43, 8765));

        // Load during COMMIT is ignored
        run_load(7'd11, 7'd22, 14'd3333, BUSY_LEN, 7'd44, 7'd55, 14'd6666, bc);
        check("commit load busy cycles", bc, BUSY_LEN);
        repeat (3) @(posedge clk); #1;
        check("commit load no restart", {31'd0, busy}, 32'd0);
        check_display("commit load", model_disp(11, 22, 3333));

        // Reset mid-conversion aborts with no COMMIT
        x = 7'd77; y = 7'd88; value = 14'd4321; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        check("abort busy before reset", {31'd0, busy}, 32'd1);
        repeat (9) @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort anode",   {24'd0, anode},   32'hFF);
        check("abort cathode", {25'd0, cathode}, 32'h7F);
        check("abort busy",    {31'd0, busy},    32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk); #1;
        check("abort stays idle", {31'd0, busy}, 32'd0);
        check_display("abort", model_disp(0, 0, 0));
        run_load(7'd33, 7'd44, 14'd555, -1, '0, '0, '0, bc);
        check("after abort busy cycles", bc, BUSY_LEN);
        check_display("after abort", model_disp(33, 44, 555));

        // Randomized loads against the model
        for (int i = 0; i < 10; i++) begin
            rx = 7'($urandom_range(0, 127));
            ry = 7'($urandom_range(0, 127));
            rv = 14'($urandom_range(0, 16383));
            if (i % 3 == 0) rv = 14'($urandom_range(0, 120));
            run_load(rx, ry, rv, -1, '0, '0, '0, bc);
            check($sformatf("rand%0d busy cycles", i), bc, BUSY_LEN);
            check_display($sformatf("rand%0d x=%0d y=%0d v=%0d", i, rx, ry, rv),
                          model_disp(int'(rx), int'(ry), int'(rv)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 200000, meaning clk cycles per digit-advance tick (100 MHz / 200000 = 500 Hz).
REQ-002 SHALL have parameter LZ_BLANK, default 1, meaning blank leading zeros of the 4-digit value field.
REQ-003 clk  input  1  system clock, 100 MHz; sole clock.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 load  input  1  single-cycle request to capture x, y, value.
REQ-006 x  input  7  unsigned coordinate, displayed as 2 digits.
REQ-007 y  input  7  unsigned coordinate, displayed as 2 digits.
REQ-008 value  input  14  unsigned number, displayed as 4 digits.
REQ-009 busy  output  1  high while a capture/conversion is in progress.
REQ-010 anode  output  8  active-low one-hot digit select.
REQ-011 cathode  output  7  active-low segments, bit6..0 = g..a.

Function
REQ-012 The FSM SHALL have states IDLE, CONV_V, CONV_X, CONV_Y and COMMIT.
REQ-013 In IDLE, load=1 SHALL capture x, y and value, then enter CONV_V on the next edge, with busy=1 from that edge.
REQ-014 Capture SHALL saturate out-of-range inputs: x>99 and y>99 become 99, and value>9999 becomes 9999.
REQ-015 Conversion SHALL use a shift-add-3 (double-dabble) engine, 1 bit per cycle, shared by all three fields.
REQ-016 State durations SHALL be: CONV_V 14 cycles, CONV_X 7 cycles, CONV_Y 7 cycles, COMMIT 1 cycle (29 cycles total).
REQ-017 COMMIT SHALL write all 8 BCD digits to the display register atomically, then return to IDLE with busy=0 on the next edge.
REQ-018 Scanning SHALL show the new digits starting on the cycle after COMMIT; partial results SHALL never be displayed.
REQ-019 load while busy=1 SHALL be ignored, with no queuing and no effect on the conversion in progress.
REQ-020 load asserted on the same cycle COMMIT completes SHALL be ignored; it is accepted only when the state is IDLE.
REQ-021 The prescaler SHALL count 0..CLK_DIV-1 and emit a 1-cycle tick at the terminal count.
REQ-022 The 3-bit digit index SHALL advance on each tick and wrap from 7 to 0.
REQ-023 Digit map SHALL be: idx0 x ones, idx1 x tens, idx2 y ones, idx3 y tens, idx4..7 value ones, tens, hundreds, thousands.
REQ-024 anode SHALL equal ~(1<<idx) and SHALL be registered, changing only on the tick edge.
REQ-025 cathode SHALL be registered in the same cycle as anode, so that no cross-digit ghosting occurs.
REQ-026 Segment codes 0..9 SHALL be: 40,79,24,30,19,12,02,78,00,18 (hex, active-low).
REQ-027 A non-decimal nibble SHALL drive cathode 7F (blank).
REQ-028 With LZ_BLANK=1, value digits above the most significant non-zero digit SHALL drive 7F.
REQ-029 A value of 0 SHALL show a single "0" at idx4; x and y fields SHALL never be blanked.
REQ-030 Scanning SHALL run continuously, independent of the FSM state.

Reset
REQ-031 rst_n=0 SHALL asynchronously force: state IDLE, busy 0, prescaler 0, idx 0, all digits 0, anode FF, cathode 7F.
REQ-032 Reset asserted mid-conversion SHALL abort the conversion with no COMMIT.
REQ-033 After rst_n deassertion, the first tick SHALL select idx 0 (anode FE).

Structure
REQ-034 Package seg_pkg SHALL hold the state enum, the SEG_CODE[0:9] table, SEG_BLANK=7'h7F and ANODE_OFF=8'hFF.
REQ-035 Sub-module bcd_dd SHALL be a sequential double-dabble engine with start, 14-bit operand and width select (7/14), done and a 16-bit BCD result; it is reused for all three fields.

Verification
REQ-036 Reset, then load x=12 y=34 value=5678 -> busy high 29 cycles; digits idx0..7 = 2,1,4,3,8,7,6,5; cathode at idx4 = 00.
REQ-037 Load x=120 y=7 value=12000 -> displays x=99, y=07, value=9999.
REQ-038 value=42 with LZ_BLANK=1 -> idx6 and idx7 cathode = 7F, idx5 = 19; value=0 -> idx4 = 40, idx5..7 = 7F.
REQ-039 Second load 5 cycles after the first -> ignored; the display reflects the first load only.
REQ-040 rst_n pulse at cycle 10 of a conversion -> anode FF, cathode 7F, busy 0; no COMMIT occurs; the next load completes normally.
REQ-041 CLK_DIV=2 -> anode steps FE,FD,FB,...,7F,FE every 2 cycles with correct wrap.
